// File: rtl/mem_pkg.sv
// Shared definitions for the main-memory arbiter and its memory model:
// FSM state encoding, cache-line geometry and the default access latency.
package mem_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_IFILL  = 3'd1,
    S_DWB    = 3'd2,
    S_DFILL  = 3'd3,
    S_DONE_I = 3'd4,
    S_DONE_D = 3'd5
  } state_e;

  localparam int LINE_BYTES      = 16;
  localparam int LINE_OFF_MASK   = LINE_BYTES - 1;
  localparam int MEM_LATENCY_DEF = 5;

  // A latency of 1 still needs a one-bit counter.
  function automatic int cnt_width(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the I-miss, D-miss and memory-port signals around mem_arbiter.
// slave = the arbiter; master = the caches plus the memory they share.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
);

  logic              ireq;
  logic [ADDR_W-1:0] iaddr;
  logic              iack;
  logic [LINE_W-1:0] iline;

  logic              dreq;
  logic [ADDR_W-1:0] daddr;
  logic              ddirty;
  logic [ADDR_W-1:0] dvaddr;
  logic [LINE_W-1:0] dvline;
  logic              dack;
  logic [LINE_W-1:0] dline;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wline;
  logic [LINE_W-1:0] mem_rline;

  logic              busy;

  modport slave (
    input  ireq, iaddr, dreq, daddr, ddirty, dvaddr, dvline, mem_rline,
    output iack, iline, dack, dline, mem_en, mem_we, mem_addr, mem_wline, busy
  );

  modport master (
    output ireq, iaddr, dreq, daddr, ddirty, dvaddr, dvline, mem_rline,
    input  iack, iline, dack, dline, mem_en, mem_we, mem_addr, mem_wline, busy
  );

endinterface

// File: rtl/lat_counter.sv
// Loadable down-counter timing one memory phase; saturates at zero.
module lat_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments and an async reset
  // in the sensitivity list so it clears without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single main-memory line port between I-cache and D-cache
// misses; a dirty D-miss runs a write-back phase straight into its fill.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int MEM_LATENCY = MEM_LATENCY_DEF,
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 128
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  localparam int                CNT_W    = cnt_width(MEM_LATENCY);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_OFF_MASK);

  state_e            state_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic              iack_q;
  logic              dack_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [ADDR_W-1:0] fill_addr_q;
  logic [LINE_W-1:0] mem_wline_q;
  logic [LINE_W-1:0] iline_q;
  logic [LINE_W-1:0] dline_q;

  logic in_phase;
  logic grant;
  logic cnt_load;
  logic cnt_zero;

  function automatic logic [ADDR_W-1:0] line_of(input logic [ADDR_W-1:0] a);
    return a & ~OFF_MASK;
  endfunction

  assign in_phase = (state_q == S_IFILL) || (state_q == S_DWB) || (state_q == S_DFILL);
  assign grant    = (state_q == S_IDLE) && (bus.dreq || bus.ireq);
  // Reload at every phase start: at grant, and on the write-back to fill hand-off.
  assign cnt_load = grant || ((state_q == S_DWB) && cnt_zero);

  lat_counter #(.W(CNT_W)) u_lat_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (CNT_LOAD),
    .en       (in_phase),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      iack_q      <= 1'b0;
      dack_q      <= 1'b0;
      mem_addr_q  <= '0;
      fill_addr_q <= '0;
      mem_wline_q <= '0;
      iline_q     <= '0;
      dline_q     <= '0;
    end else begin
      iack_q <= 1'b0;
      dack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // D wins: the M-stage instruction is older than the one in F.
          if (bus.dreq) begin
            mem_en_q    <= 1'b1;
            fill_addr_q <= line_of(bus.daddr);
            if (bus.ddirty) begin
              state_q     <= S_DWB;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= line_of(bus.dvaddr);
              mem_wline_q <= bus.dvline;
            end else begin
              state_q    <= S_DFILL;
              mem_addr_q <= line_of(bus.daddr);
            end
          end else if (bus.ireq) begin
            state_q    <= S_IFILL;
            mem_en_q   <= 1'b1;
            mem_addr_q <= line_of(bus.iaddr);
          end
        end
        S_DWB: begin
          if (cnt_zero) begin
            state_q    <= S_DFILL;
            mem_we_q   <= 1'b0;
            mem_addr_q <= fill_addr_q;
          end
        end
        // The ack is registered, so a withdrawn request is seen in the last
        // memory cycle; DONE_x is still taken either way.
        S_IFILL: begin
          if (cnt_zero) begin
            state_q  <= S_DONE_I;
            mem_en_q <= 1'b0;
            iline_q  <= bus.mem_rline;
            iack_q   <= bus.ireq;
          end
        end
        S_DFILL: begin
          if (cnt_zero) begin
            state_q  <= S_DONE_D;
            mem_en_q <= 1'b0;
            dline_q  <= bus.mem_rline;
            dack_q   <= bus.dreq;
          end
        end
        S_DONE_I, S_DONE_D: state_q <= S_IDLE;
        default:            state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wline = mem_wline_q;
  assign bus.iack      = iack_q;
  assign bus.iline     = iline_q;
  assign bus.dack      = dack_q;
  assign bus.dline     = dline_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule
